flow_sender: RTL and testbench

FLOW_SENDER -- requirements
Module: flow_sender

---
 rtl/flow_sender_if.sv | 27 ++
 rtl/flow_sender.sv | 116 +++++++++++
 tb/tb_flow_sender.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_sender_if.sv
// Handshake bundle between the burst loader, flow_sender and the downstream max detector.
// master drives loads, go and detector results; slave is the sender itself.
interface flow_sender_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       go;
    logic       full;
    logic       busy;
    logic       start;
    logic [7:0] dout;
    logic       done_in;
    logic [7:0] max_in;
    logic [7:0] max_exp;
    logic       res_valid;
    logic       max_ok;
    logic       timeout;

    modport master (
        output wr_en, wr_data, go, done_in, max_in,
        input  full, busy, start, dout, max_exp, res_valid, max_ok, timeout
    );

    modport slave (
        input  wr_en, wr_data, go, done_in, max_in,
        output full, busy, start, dout, max_exp, res_valid, max_ok, timeout
    );
endinterface

// File: rtl/flow_sender.sv
// Buffers a burst of bytes, streams it to a downstream max detector and checks the
// detector's reported maximum against a locally tracked one, with a reply timeout.
module flow_sender #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TMO   = 4
) (
    input logic         clk,
    input logic         rst,
    flow_sender_if.slave bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = IW + 1;
    localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StWaitd, StReport} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [7:0]      max_q, max_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;
    logic            ok_q, ok_d;
    logic            to_q, to_d;
    logic            buf_we;
    logic [7:0]      buf_q [DEPTH];
    logic            full;

    assign full = (cnt_q == CW'(DEPTH));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        max_d    = max_q;
        wcnt_d   = wcnt_q;
        ok_d     = ok_q;
        to_d     = to_q;
        buf_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // go wins over a same-cycle write; go on an empty buffer is dropped
                if (bus.go) begin
                    if (cnt_q != '0) begin
                        state_d  = StSend;
                        rd_idx_d = '0;
                    end
                end else if (bus.wr_en && !full) begin
                    buf_we = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (bus.wr_data > max_q) max_d = bus.wr_data;
                end
            end
            StSend: begin
                rd_idx_d = rd_idx_q + IW'(1);
                if ({1'b0, rd_idx_q} == cnt_q - CW'(1)) begin
                    state_d = StWaitd;
                    wcnt_d  = '0;
                end
            end
            StWaitd: begin
                if (bus.done_in) begin
                    ok_d    = (bus.max_in == max_q);
                    to_d    = 1'b0;
                    state_d = StReport;
                end else if (wcnt_q == TW'(TMO - 1)) begin
                    ok_d    = 1'b0;
                    to_d    = 1'b1;
                    state_d = StReport;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            StReport: begin
                cnt_d    = '0;
                rd_idx_d = '0;
                max_d    = '0;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rd_idx_q <= '0;
            max_q    <= '0;
            wcnt_q   <= '0;
            ok_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
            max_q    <= max_d;
            wcnt_q   <= wcnt_d;
            ok_q     <= ok_d;
            to_q     <= to_d;
        end
    end

    // Storage is never reset; only cnt decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[cnt_q[IW-1:0]] <= bus.wr_data;
    end

    assign bus.full      = full;
    assign bus.busy      = (state_q != StIdle);
    assign bus.start     = (state_q == StSend);
    assign bus.dout      = (state_q == StSend) ? buf_q[rd_idx_q] : 8'h00;
    assign bus.max_exp   = max_q;
    assign bus.res_valid = (state_q == StReport);
    assign bus.max_ok    = ok_q;
    assign bus.timeout   = to_q;
endmodule

// File: tb/tb_flow_sender.sv
// Self-checking bench for flow_sender: directed steps with random payloads, a queue model
// of the buffered burst and a behavioural downstream max detector.
module tb_flow_sender;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // detector behaviour controls, written only by the main sequence
    bit         det_en    = 1'b1;
    bit         det_force = 1'b0;
    logic [7:0] det_val   = 8'h00;

    logic [7:0] model_q [$];

    flow_sender_if bus ();

    flow_sender #(.DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".start"}, 32'(bus.start), 0);
        chk({tag, ".dout"}, 32'(bus.dout), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
        chk({tag, ".full"}, 32'(bus.full), 0);
        chk({tag, ".res_valid"}, 32'(bus.res_valid), 0);
        chk({tag, ".max_ok"}, 32'(bus.max_ok), 0);
        chk({tag, ".timeout"}, 32'(bus.timeout), 0);
        chk({tag, ".max_exp"}, 32'(bus.max_exp), 0);
    endtask

    task automatic load(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        cycle();
        bus.wr_en   = 1'b0;
        if (model_q.size() < DEPTH) model_q.push_back(b);
        chk("load.full", 32'(bus.full), 32'(model_q.size() == DEPTH));
    endtask

    // Downstream max detector: accumulates the frame, answers on the cycle after start falls.
    initial begin
        logic [7:0] acc;
        bit         seen;
        acc = 8'h00;
        seen = 1'b0;
        bus.done_in = 1'b0;
        bus.max_in  = 8'h00;
        forever begin
            cycle();
            if (bus.start === 1'b1) begin
                if (!seen || bus.dout > acc) acc = bus.dout;
                seen = 1'b1;
                bus.done_in = 1'b0;
            end else if (seen) begin
                seen = 1'b0;
                if (det_en) begin
                    bus.done_in = 1'b1;
                    bus.max_in  = det_force ? det_val : acc;
                end
                acc = 8'h00;
            end else begin
                bus.done_in = 1'b0;
                bus.max_in  = 8'h00;
            end
        end
    end

    // Pulse go and check beats, result and return to idle against the queue model.
    task automatic run_burst(input string tag, input bit with_wr);
        logic [7:0] got [$];
        logic [7:0] exp_max;
        bit         exp_ok;
        bit         exp_to;
        int         n;
        int         lat;
        exp_max = 8'h00;
        foreach (model_q[i]) if (model_q[i] > exp_max) exp_max = model_q[i];
        exp_to = !det_en;
        exp_ok = det_en && (!det_force || det_val == exp_max);

        bus.go = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(($urandom % 256));
        end
        cycle();
        bus.go = 1'b0;
        n = 0;
        while (bus.start === 1'b1 && n < DEPTH + 2) begin
            got.push_back(bus.dout);
            if (with_wr) bus.wr_data = 8'(($urandom % 256));
            cycle();
            n++;
        end
        bus.wr_en = 1'b0;
        chk({tag, ".beats"}, 32'(got.size()), 32'(model_q.size()));
        for (int i = 0; i < got.size() && i < model_q.size(); i++)
            chk($sformatf("%s.dout[%0d]", tag, i), 32'(got[i]), 32'(model_q[i]));
        chk({tag, ".dout_idle"}, 32'(bus.dout), 0);
        chk({tag, ".busy_wait"}, 32'(bus.busy), 1);
        chk({tag, ".max_exp"}, 32'(bus.max_exp), 32'(exp_max));

        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < TMO + 4) begin
            cycle();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), det_en ? 1 : TMO);
        chk({tag, ".res_valid"}, 32'(bus.res_valid), 1);
        chk({tag, ".max_ok"}, 32'(bus.max_ok), 32'(exp_ok));
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(exp_to));
        cycle();
        chk({tag, ".res_pulse"}, 32'(bus.res_valid), 0);
        chk({tag, ".busy_idle"}, 32'(bus.busy), 0);
        chk({tag, ".max_clr"}, 32'(bus.max_exp), 0);
        chk({tag, ".full_clr"}, 32'(bus.full), 0);
        chk({tag, ".max_ok_hold"}, 32'(bus.max_ok), 32'(exp_ok));
        chk({tag, ".timeout_hold"}, 32'(bus.timeout), 32'(exp_to));
        model_q.delete();
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.go      = 1'b0;

        // reset state
        #2;
        chk_all_zero("reset");
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk_all_zero("post_reset");

        // directed 3,9,5 burst
        load(8'd3);
        load(8'd9);
        load(8'd5);
        run_burst("b395", 1'b0);

        // random-length random burst
        begin
            int len;
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load(8'($urandom % 256));
            run_burst("rand", 1'b0);
        end

        // full buffer, ninth write dropped
        for (int i = 0; i < DEPTH; i++) load(8'($urandom % 256));
        chk("full.set", 32'(bus.full), 1);
        load(8'hA5);
        run_burst("full", 1'b0);

        // no detector response
        det_en = 1'b0;
        for (int i = 0; i < 3; i++) load(8'($urandom % 256));
        run_burst("tmo", 1'b0);
        det_en = 1'b1;

        // wrong maximum reported
        det_force = 1'b1;
        det_val   = 8'h07;
        load(8'h09);
        load(8'h02);
        load(8'h05);
        run_burst("badmax", 1'b0);
        det_force = 1'b0;

        // go with an empty buffer
        bus.go = 1'b1;
        cycle();
        bus.go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("empty_go.busy", 32'(bus.busy), 0);
            chk("empty_go.start", 32'(bus.start), 0);
            cycle();
        end

        // write alongside go is dropped, and writes during the burst too
        load(8'($urandom % 256));
        load(8'($urandom % 256));
        run_burst("wr_go", 1'b1);

        // reset during the second beat
        for (int i = 0; i < 3; i++) load(8'($urandom % 256));
        bus.go = 1'b1;
        cycle();
        bus.go = 1'b0;
        chk("mid.beat1", 32'(bus.start), 1);
        cycle();
        chk("mid.beat2", 32'(bus.dout), 32'(model_q[1]));
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        cycle();
        rst = 1'b0;
        model_q.delete();
        cycle();
        cycle();
        load(8'($urandom % 256));
        run_burst("after_rst", 1'b0);

        // random bursts with random detector behaviour
        for (int k = 0; k < 6; k++) begin
            int len;
            det_en    = ($urandom % 4) != 0;
            det_force = ($urandom % 3) == 0;
            det_val   = 8'($urandom % 256);
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) load(8'($urandom % 256));
            run_burst($sformatf("loop%0d", k), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
